// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared arbiter state encoding, master IDs and default bus widths.
package riscv_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;
    localparam logic MST_IF     = 1'b0;
    localparam logic MST_EX     = 1'b1;
    localparam int   DEF_ADDR_W = 32;
    localparam int   DEF_DATA_W = 32;
endpackage

// File: rtl/bus_timeout_timer.sv
// bus_timeout_timer: counts enabled cycles since the last load and flags the
// cycle in which TIMEOUT_CYC of them have elapsed.
module bus_timeout_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    assign o_expire = i_en && (r_cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port slave bus between fetch (M0) and load/store (M1).
// Define ARB_TIMEOUT_EN to abort hung address/data phases with a bus_err pulse.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_gnt,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                owner,
    output logic                fetch_stall,
    output logic                bus_err
);
    arb_state_e r_state, w_step, w_next;
    logic r_owner, r_we, w_win, w_timeout;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_m0_rdata, r_m1_rdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [3:0] r_starve;
    // M1 has priority unless M0 has already lost STARVE_MAX arbitrations in a row.
    assign w_win = m1_req && !(m0_req && r_starve == 4'(STARVE_MAX));
    always_comb begin
        w_step = r_state;
        case (r_state)
            IDLE:    w_step = (m0_req || m1_req) ? ADDR : IDLE;
            ADDR:    w_step = s_gnt ? (s_rvalid ? RESP : DATA) : ADDR;
            DATA:    w_step = s_rvalid ? RESP : DATA;
            default: w_step = IDLE;
        endcase
    end
    assign w_next = w_timeout ? RESP : w_step;
`ifdef ARB_TIMEOUT_EN
    logic r_err;
    bus_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_load   (w_step != r_state),
        .i_en     (r_state == ADDR || r_state == DATA),
        .o_expire (w_timeout)
    );
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst)
            r_err <= 1'b0;
        else
            r_err <= w_timeout;
    assign bus_err = r_err;
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_owner    <= MST_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_starve   <= 4'd0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_starve <= !(m0_req && w_win) ? 4'd0 :
                            (r_starve == 4'(STARVE_MAX)) ? r_starve : r_starve + 4'd1;
                if (m0_req || m1_req) begin
                    r_owner <= w_win;
                    r_we    <= w_win && m1_we;
                    r_addr  <= w_win ? m1_addr : m0_addr;
                    r_wdata <= w_win ? m1_wdata : '0;
                    r_wstrb <= w_win ? m1_wstrb : '0;
                end
            end
            // Response data is captured on entry to RESP; an aborted phase returns zero.
            if (w_next == RESP && r_state != RESP) begin
                if (r_owner == MST_EX)
                    r_m1_rdata <= w_timeout ? '0 : s_rdata;
                else
                    r_m0_rdata <= w_timeout ? '0 : s_rdata;
            end
        end
    end
    assign s_req       = (r_state == ADDR);
    assign s_we        = r_we;
    assign s_addr      = r_addr;
    assign s_wdata     = r_wdata;
    assign s_wstrb     = r_wstrb;
    assign m0_gnt      = s_req && s_gnt && r_owner == MST_IF;
    assign m1_gnt      = s_req && s_gnt && r_owner == MST_EX;
    assign m0_rvalid   = (r_state == RESP) && r_owner == MST_IF;
    assign m1_rvalid   = (r_state == RESP) && r_owner == MST_EX;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign owner       = r_owner;
    assign fetch_stall = m0_req && !(r_owner == MST_IF && r_state == RESP);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_bus_arbiter;
    logic        sys_clk, sys_rst;
    logic        m0_req, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb, s_wstrb;
    logic        s_req, s_we, s_gnt, s_rvalid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        owner, fetch_stall, bus_err;
    int checks = 0;
    int failures = 0;
    logic [5:0] exp_own;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .owner(owner), .fetch_stall(fetch_stall), .bus_err(bus_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic next();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic m0_read(input logic [31:0] addr, input logic [31:0] data);
        next(); m0_req = 1'b1; m0_addr = addr; #1;
        chk("rd_stall_pending", fetch_stall, 1);
        chk("rd_sreq_idle", s_req, 0);
        next(); s_gnt = 1'b1; #1;
        chk("rd_addr", s_addr, addr);
        chk("rd_we_wstrb", {s_we, s_wstrb}, 0);
        chk("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
        next(); m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = data; #1;
        chk("rd_data_phase", {s_req, m0_gnt, m0_rvalid}, 0);
        next(); s_rvalid = 1'b0; s_rdata = 32'h0; #1;
        chk("rd_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("rd_rdata", m0_rdata, data);
        chk("rd_stall_after", fetch_stall, 0);
        next(); #1;
        chk("rd_single_pulse", m0_rvalid, 0);
        chk("rd_rdata_hold", m0_rdata, data);
    endtask

    initial begin
        sys_rst = 1'b1;
        m0_req = 0; m0_addr = 0; m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0;
        exp_own = 6'b101111;
        next(); next(); #1;
        chk("rst_outputs", {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_req, s_we, owner, fetch_stall, bus_err}, 0);
        chk("rst_bus", {s_addr, s_wdata}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        next(); sys_rst = 1'b0;

        // zero-wait fetch
        m0_read(32'h0000_0010, 32'hDEAD_BEEF);

        // reset in the middle of a load data phase
        next(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; #1;
        next(); s_gnt = 1'b1; #1;
        chk("mr_gnt", m1_gnt, 1);
        next(); m1_req = 1'b0; s_gnt = 1'b0; #1;
        chk("mr_data_sreq", s_req, 0);
        sys_rst = 1'b1; #1;
        chk("mr_rst_outputs", {m0_rvalid, m1_rvalid, s_req, owner, bus_err}, 0);
        chk("mr_rst_rdata", m0_rdata, 0);
        next(); sys_rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_2222; #1;
        chk("mr_no_stale1", {m0_rvalid, m1_rvalid, s_req}, 0);
        next(); s_rvalid = 1'b0; s_rdata = 0; #1;
        chk("mr_no_stale2", {m0_rvalid, m1_rvalid, s_req}, 0);
        m0_read(32'h0000_0014, 32'hCAFE_F00D);

        // simultaneous requests: M1 store first, then M0 fetch
        next();
        m0_req = 1'b1; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; #1;
        chk("both_stall", fetch_stall, 1);
        next(); s_gnt = 1'b1; #1;
        chk("both_owner_m1", owner, 1);
        chk("both_store_fields", {s_we, s_wstrb, s_addr, s_wdata}, {1'b1, 4'hF, 32'h100, 32'h1234_5678});
        chk("both_gnt_m1", {m1_gnt, m0_gnt}, 2'b10);
        next(); m1_req = 1'b0; m1_we = 1'b0; m1_wstrb = 4'h0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0; #1;
        chk("both_stall_data", fetch_stall, 1);
        next(); s_rvalid = 1'b0; #1;
        chk("both_ack_m1", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("both_stall_m1_resp", fetch_stall, 1);
        next(); #1;
        chk("both_idle_sreq", s_req, 0);
        next(); s_gnt = 1'b1; #1;
        chk("both_owner_m0", owner, 0);
        chk("both_m0_fields", {s_we, s_wstrb, s_addr}, {1'b0, 4'h0, 32'h20});
        chk("both_gnt_m0", {m1_gnt, m0_gnt}, 2'b01);
        next(); m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hA5A5_0001; #1;
        next(); s_rvalid = 1'b0; #1;
        chk("both_rvalid_m0", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("both_rdata_m0", m0_rdata, 32'hA5A5_0001);

        // starvation guard: slave grants and responds in the same cycle
        next();
        m0_req = 1'b1; m0_addr = 32'h40; m1_req = 1'b1; m1_addr = 32'h300;
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 6; k++) begin
            next(); #1;
            chk("starve_owner", owner, exp_own[k]);
            chk("starve_gnt", {m1_gnt, m0_gnt}, exp_own[k] ? 2'b10 : 2'b01);
            next(); #1;
            chk("starve_rvalid", {m1_rvalid, m0_rvalid}, exp_own[k] ? 2'b10 : 2'b01);
            chk("starve_stall", fetch_stall, exp_own[k]);
            next();
        end
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 0;
        chk("starve_m0_rdata", m0_rdata, 32'h5A5A_5A5A);

        // slave stalls the address phase, then grants and responds together
        next(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h400; #1;
        for (int i = 0; i < 3; i++) begin
            next(); m1_addr = 32'hDEAD_0000; #1;
            chk("wait_sreq", {s_req, s_we}, 2'b10);
            chk("wait_addr", s_addr, 32'h400);
            chk("wait_no_pulse", {m1_gnt, m1_rvalid}, 0);
        end
        next(); s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; #1;
        chk("wait_gnt", {s_req, m1_gnt, m1_rvalid}, 3'b110);
        chk("wait_addr_last", s_addr, 32'h400);
        next(); m1_req = 1'b0; m1_addr = 0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 0; #1;
        chk("wait_rvalid", {s_req, m1_rvalid}, 2'b01);
        chk("wait_rdata", m1_rdata, 32'h0BAD_F00D);
        next(); #1;
        chk("wait_single_pulse", m1_rvalid, 0);
        chk("wait_rdata_hold", m1_rdata, 32'h0BAD_F00D);

`ifdef ARB_TIMEOUT_EN
        next(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h500; m1_wdata = 32'h77; m1_wstrb = 4'h3; #1;
        next(); s_gnt = 1'b1; #1;
        chk("to_gnt", m1_gnt, 1);
        next(); m1_req = 1'b0; s_gnt = 1'b0; #1;
        for (int i = 0; i < 7; i++) begin
            chk("to_wait", {bus_err, m1_rvalid}, 0);
            next(); #1;
        end
        chk("to_wait_last", {bus_err, m1_rvalid}, 0);
        next(); #1;
        chk("to_err_rvalid", {bus_err, m1_rvalid, s_req}, 3'b110);
        chk("to_rdata_zero", m1_rdata, 0);
        next(); #1;
        chk("to_idle", {bus_err, m1_rvalid, s_req}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
